// File: rtl/instr_loader_pkg.sv
// Types and helpers shared by the instruction loader.
`ifndef INSTR_LOADER_DEFINES_SV
`include "instr_loader_defines.sv"
`endif

package instr_loader_pkg;

    localparam int PC_W    = `PC_WIDTH;
    localparam int INSTR_W = `INSTR_WIDTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Pointer increment that wraps from the last valid address back to 0.
    function automatic logic [PC_W-1:0] ptr_next(input logic [PC_W-1:0] p,
                                                 input logic [PC_W-1:0] last);
        return (p == last) ? '0 : p + PC_W'(1);
    endfunction

endpackage

// File: rtl/instr_loader_defines.sv
// Shared widths and host opcode encodings for the instruction loader and its parent.
`ifndef INSTR_LOADER_DEFINES_SV
`define INSTR_LOADER_DEFINES_SV

`define PC_WIDTH     8
`define INSTR_WIDTH  32

`define OP_START     2'b00
`define OP_SET_ADDR  2'b01
`define OP_WRITE     2'b10
`define OP_CLEAR     2'b11

`endif

// File: rtl/instr_loader.sv
// Host-driven instruction loader: sets a write pointer, streams words into
// instruction memory, sweeps it to zero, and gates core execution.
`ifndef INSTR_LOADER_DEFINES_SV
`include "instr_loader_defines.sv"
`endif

module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [`INSTR_WIDTH-1:0] cmd_data,
    output logic                    mem_we,
    output logic [`PC_WIDTH-1:0]    mem_waddr,
    output logic [`INSTR_WIDTH-1:0] mem_wdata,
    output logic                    core_run,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [PC_W:0]   DEPTH_X = (PC_W+1)'(DEPTH);
    localparam logic [PC_W-1:0] LAST    = PC_W'(DEPTH - 1);

    state_t          state;
    logic [PC_W-1:0] ptr;
    logic            mem_we_q;
    logic [PC_W-1:0] set_addr;
    logic            set_in_range;

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_valid alone has no effect.
    assign cmd_ready    = (state == ST_IDLE) && rst_n;
    assign set_addr     = cmd_data[PC_W-1:0];
    assign set_in_range = ({1'b0, set_addr} < DEPTH_X);

    // Gating with rst_n drops a write still pending when reset arrives.
    assign mem_we = mem_we_q & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            mem_we_q  <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            core_run  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            `OP_START: begin
                                core_run <= 1'b1;
                            end
                            `OP_SET_ADDR: begin
                                core_run <= 1'b0;
                                if (set_in_range) begin
                                    ptr <= set_addr;
                                end else begin
                                    ptr <= '0;
                                    err <= 1'b1;
                                end
                            end
                            `OP_WRITE: begin
                                core_run  <= 1'b0;
                                mem_we_q  <= 1'b1;
                                mem_waddr <= ptr;
                                mem_wdata <= cmd_data;
                                ptr       <= ptr_next(ptr, LAST);
                            end
                            default: begin
                                // First sweep write goes out with acceptance.
                                core_run  <= 1'b0;
                                state     <= ST_CLEAR;
                                busy      <= 1'b1;
                                mem_we_q  <= 1'b1;
                                mem_waddr <= '0;
                                mem_wdata <= '0;
                                ptr       <= ptr_next('0, LAST);
                            end
                        endcase
                    end
                end
                ST_CLEAR: begin
                    // ptr wrapping back to 0 marks the sweep as complete.
                    if (ptr == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        mem_we_q  <= 1'b1;
                        mem_waddr <= ptr;
                        mem_wdata <= '0;
                        ptr       <= ptr_next(ptr, LAST);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 128: number of instruction-memory words to be sequenced (2..2^`PC_WIDTH).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1: host command present.
REQ-005 SHALL have port cmd_ready, output, 1: block accepts a command this cycle.
REQ-006 SHALL have port cmd_op, input, 2: 00 START, 01 SET_ADDR, 10 WRITE, 11 CLEAR.
REQ-007 SHALL have port cmd_data, input, `INSTR_WIDTH: instruction word (WRITE) or address in bits [`PC_WIDTH-1:0] (SET_ADDR).
REQ-008 SHALL have port mem_we, output, 1: instruction-memory write enable.
REQ-009 SHALL have port mem_waddr, output, `PC_WIDTH: instruction-memory write address.
REQ-010 SHALL have port mem_wdata, output, `INSTR_WIDTH: instruction-memory write data.
REQ-011 SHALL have port core_run, output, 1: core may fetch/execute; low while memory is being altered.
REQ-012 SHALL have port busy, output, 1: CLEAR sweep in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at CLEAR completion.
REQ-014 SHALL have port err, output, 1: sticky flag, out-of-range SET_ADDR seen.

Function
REQ-015 SHALL implement states IDLE and CLEAR; cmd_ready = (state==IDLE) and rst_n high, combinational.
REQ-016 SHALL accept a command only on a cycle with cmd_valid and cmd_ready both high; cmd_valid without cmd_ready SHALL have no effect.
REQ-017 SHALL hold an internal write pointer ptr, `PC_WIDTH bits, 0 after reset.
REQ-018 SET_ADDR SHALL load ptr from cmd_data[`PC_WIDTH-1:0] if the value < DEPTH; otherwise ptr SHALL become 0 and err SHALL set.
REQ-019 WRITE SHALL, on the following cycle, present mem_we=1, mem_waddr=ptr, mem_wdata=cmd_data (1-cycle registered latency), and SHALL advance ptr by 1, wrapping DEPTH-1 -> 0.
REQ-020 Back-to-back WRITEs SHALL produce one write per cycle at consecutive addresses with no bubbles.
REQ-021 mem_we SHALL be 0 on every cycle not driven by REQ-019 or REQ-022.
REQ-022 CLEAR SHALL enter CLEAR with busy=1, then emit DEPTH consecutive writes of all-zero data to addresses 0..DEPTH-1, one per cycle starting the cycle after acceptance.
REQ-023 After the write to DEPTH-1, the block SHALL return to IDLE, pulse done for exactly one cycle (same cycle busy falls) and set ptr to 0.
REQ-024 START SHALL set core_run to 1 on the next cycle; ptr and memory SHALL be unaffected.
REQ-025 Acceptance of SET_ADDR, WRITE or CLEAR SHALL clear core_run on the next cycle, i.e. no later than the first resulting mem_we.
REQ-026 START while core_run=1 SHALL be a no-op; err SHALL be cleared only by reset.

Reset
REQ-027 While rst_n is low at a clock edge: state=IDLE, ptr=0, mem_we=0, mem_waddr=0, mem_wdata=0, core_run=0, busy=0, done=0, err=0, and cmd_ready=0.
REQ-028 Reset asserted mid-CLEAR SHALL abort the sweep immediately; no further writes SHALL occur and done SHALL NOT pulse.
REQ-029 A pending write from a WRITE accepted on the cycle before reset SHALL NOT be emitted.

Structure
REQ-030 `PC_WIDTH and `INSTR_WIDTH SHALL come from the shared defines include; opcode encodings SHALL be defined there as shared constants.
REQ-031 The block SHALL be a single flat module with no sub-module; the instruction memory SHALL be instantiated by the parent and driven through mem_we/mem_waddr/mem_wdata.

Verification
REQ-032 Reset then SET_ADDR 5, WRITE 0xA, 0xB, 0xC back-to-back -> mem_we high 3 consecutive cycles, addresses 5,6,7, data A,B,C.
REQ-033 SET_ADDR DEPTH-1 (127), WRITE x2 -> writes to 127 then 0.
REQ-034 CLEAR with DEPTH=128 -> cmd_ready low 128 cycles, 128 zero writes to 0..127, done one cycle, then cmd_ready=1 and ptr=0.
REQ-035 START -> core_run=1; then WRITE -> core_run=0 in the same cycle as mem_we=1.
REQ-036 SET_ADDR 200 (DEPTH=128) -> err=1 and stays set; next WRITE targets address 0.
REQ-037 Reset asserted 10 cycles into CLEAR -> no further mem_we, no done pulse, all outputs at REQ-027 values.
